// File: rtl/v_issue_encoder.sv
// Encodes scalar-side vector requests into RVV 1.0 instruction words and
// queues them in a small FIFO; issue stalls after a vsetvli until cfg_done.
module v_issue_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_class,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_src_sel,
  input  logic [4:0]  req_vd,
  input  logic [4:0]  req_src1,
  input  logic [4:0]  req_src2,
  input  logic [10:0] req_vtype,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        cfg_done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {RUN, CFG_WAIT} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        full;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] head;
  logic        head_is_cfg;

  logic        enc_legal;
  logic [31:0] enc_word;
  logic        is_opv;
  logic [5:0]  funct6;
  logic [2:0]  funct3;
  logic [2:0]  opi_f3;
  logic        opi_ok;
  logic [4:0]  vs2;
  logic [31:0] alt_word;

  always_comb begin
    opi_ok = (req_src_sel != 2'd3);
    case (req_src_sel)
      2'd1:    opi_f3 = 3'b100;
      2'd2:    opi_f3 = 3'b011;
      default: opi_f3 = 3'b000;
    endcase
  end

  always_comb begin
    enc_legal = 1'b0;
    is_opv    = 1'b1;
    funct6    = 6'd0;
    funct3    = 3'd0;
    vs2       = req_src2;
    alt_word  = 32'd0;
    case (req_class)
      3'd0: begin
        funct3    = opi_f3;
        enc_legal = opi_ok;
        case (req_op)
          4'd1:    funct6 = 6'b000000;
          4'd2:    funct6 = 6'b000010;
          4'd3:    funct6 = 6'b001001;
          4'd4:    funct6 = 6'b001010;
          4'd5:    funct6 = 6'b001011;
          4'd6:    funct6 = 6'b100101;
          4'd7:    funct6 = 6'b101000;
          4'd8:    funct6 = 6'b101001;
          4'd9:    funct6 = 6'b000101;
          4'd10:   funct6 = 6'b000111;
          default: enc_legal = 1'b0;
        endcase
      end
      3'd1: begin
        enc_legal = (req_op == 4'd1) && (req_src_sel <= 2'd1);
        funct6    = 6'b100101;
        funct3    = (req_src_sel == 2'd0) ? 3'b010 : 3'b110;
      end
      3'd2: begin
        enc_legal = (req_src_sel == 2'd0) && ((req_op == 4'd1) || (req_op == 4'd2));
        funct6    = (req_op == 4'd1) ? 6'b000000 : 6'b000111;
        funct3    = 3'b010;
      end
      3'd3: begin
        case (req_op)
          4'd1, 4'd2: begin
            enc_legal = (req_src_sel == 2'd1) || (req_src_sel == 2'd2);
            funct6    = (req_op == 4'd1) ? 6'b001110 : 6'b001111;
            funct3    = opi_f3;
          end
          4'd3, 4'd4: begin
            enc_legal = (req_src_sel == 2'd1);
            funct6    = (req_op == 4'd3) ? 6'b001110 : 6'b001111;
            funct3    = 3'b110;
          end
          4'd5: begin
            enc_legal = opi_ok;
            funct6    = 6'b010111;
            funct3    = opi_f3;
            vs2       = 5'd0;
          end
          default: enc_legal = 1'b0;
        endcase
      end
      3'd4, 3'd5: begin
        // Width code 3 and any op with bit 3 set have no encoding here.
        is_opv    = 1'b0;
        enc_legal = !req_op[3] && (req_op[1:0] != 2'd3);
        case (req_op[1:0])
          2'd1:    funct3 = 3'b101;
          2'd2:    funct3 = 3'b110;
          default: funct3 = 3'b000;
        endcase
        alt_word = {4'b0000, req_op[2], 1'b0, 1'b1,
                    req_op[2] ? req_src2 : 5'd0, req_src1, funct3, req_vd,
                    (req_class == 3'd4) ? 7'b0000111 : 7'b0100111};
      end
      3'd6: begin
        is_opv    = 1'b0;
        enc_legal = (req_op == 4'd0);
        alt_word  = {1'b0, req_vtype, req_src1, 3'b111, req_vd, 7'b1010111};
      end
      default: enc_legal = 1'b0;
    endcase
    enc_word = is_opv ? {funct6, 1'b1, vs2, req_src1, funct3, req_vd, 7'b1010111}
                      : alt_word;
  end

  assign full        = (count == FULL_CNT);
  assign req_ready   = nrst && !full;
  assign accept      = req_valid && req_ready;
  assign push        = accept && enc_legal;
  assign head        = mem[rd_ptr];
  assign instr       = (count != '0) ? head : 32'd0;
  assign instr_valid = (state == RUN) && (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign head_is_cfg = (head[6:0] == 7'b1010111) && (head[14:12] == 3'b111);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Pointer, occupancy, error pulse and issue-stall state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      state  <= RUN;
    end else begin
      err <= accept && !enc_legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        RUN:      if (pop && head_is_cfg) state <= CFG_WAIT;
        CFG_WAIT: if (cfg_done) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/v_issue_encoder.md
V_ISSUE_ENCODER -- requirements
Module: v_issue_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of entries in the encoded-instruction FIFO (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nrst, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, scalar-side request valid.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_class, input, 3, operation class: 0 ALU, 1 MUL, 2 RED, 3 SLDU, 4 LOAD, 5 STORE, 6 CFG, 7 illegal.
REQ-007 SHALL have port req_op, input, 4, the op within the class (REQ-014).
REQ-008 SHALL have port req_src_sel, input, 2, operand-A form: 0 VV, 1 VX, 2 VI, 3 illegal.
REQ-009 SHALL have ports req_vd (input, 5: vd/rd/vs3), req_src1 (input, 5: vs1/rs1/simm5) and req_src2 (input, 5: vs2/rs2 stride), plus req_vtype (input, 11: zimm for CFG).
REQ-010 SHALL have port instr, output, 32, the encoded RVV 1.0 instruction at the FIFO head.
REQ-011 SHALL have ports instr_valid (output, 1) and instr_ready (input, 1); instr transfers when both are high.
REQ-012 SHALL have ports cfg_done (input, 1: the coprocessor finished a vsetvli) and err (output, 1: illegal-request pulse).

Function
REQ-013 SHALL build the OP-V layout as: [31:26] funct6, [25] vm=1, [24:20] vs2, [19:15] src1, [14:12] funct3, [11:7] vd, [6:0] 1010111.
REQ-014 SHALL encode funct6/funct3 as follows.
- ALU op 1..10 = vadd 000000, vsub 000010, vand 001001, vor 001010, vxor 001011, vsll 100101, vsrl 101000, vsra 101001, vmin 000101, vmax 000111; funct3 is OPIVV 000, OPIVX 100 or OPIVI 011 per src_sel.
- MUL op1 = vmul 100101; funct3 is OPMVV 010 or OPMVX 110; VI is illegal.
- RED op1 = vredsum 000000, op2 = vredmax 000111; VV only, funct3 010.
- SLDU: op1 vslideup 001110 and op2 vslidedown 001111 take VX/VI with OPI funct3; op3 vslide1up 001110 and op4 vslide1down 001111 take VX only with funct3 110; op5 vmv 010111 takes VV/VX/VI with OPI funct3 and forces vs2=0.
REQ-015 SHALL encode LOAD/STORE as: req_op[1:0] is width (0=8→000, 1=16→101, 2=32→110, 3 illegal) and req_op[2] is strided (mop 10, [24:20]=src2), else unit-stride (mop 00, [24:20]=0).
- [31:28]=0, [25]=1, [19:15]=src1, [11:7]=vd.
- Opcode is 0000111 for LOAD and 0100111 for STORE.
REQ-016 SHALL encode CFG op0 (vsetvli) as [31]=0, [30:20]=vtype, [19:15]=src1, [14:12]=111, [11:7]=vd, opcode 1010111.
REQ-017 SHALL treat any class/op/src_sel combination not listed as illegal: the request is consumed (handshake completes), nothing is enqueued, and err is high for exactly the next cycle.
REQ-018 SHALL drive req_ready = !full; there is no bypass, so a pop and a push in the same cycle while full does not accept the request.
REQ-019 SHALL make a legal request accepted at edge N visible on instr at edge N+1 when the FIFO was empty (1-cycle latency).
REQ-020 SHALL support simultaneous push and pop (non-full), leaving the count unchanged; pointers wrap modulo DEPTH.
REQ-021 SHALL implement FSM states RUN and CFG_WAIT.
- In RUN: instr_valid = !empty.
- RUN→CFG_WAIT: when the popped instruction has opcode 1010111 and funct3 111.
- In CFG_WAIT: instr_valid = 0 and the FIFO still accepts pushes.
- CFG_WAIT→RUN: on cfg_done.
- cfg_done in RUN, including the same cycle as the vsetvli pop, SHALL be ignored.
REQ-022 SHALL keep instr stable while instr_valid && !instr_ready.

Reset
REQ-023 SHALL, while nrst=0, flush the FIFO (count 0), set state RUN, drive instr_valid=0, err=0 and instr=0, and drive req_ready=0.
REQ-024 SHALL, on reset asserted mid-operation, discard queued and in-flight entries; the first cycle after release has req_ready=1 and instr_valid=0.

Verification
REQ-025 SHALL cover: ALU vadd VV, vd=3, src1=1, src2=2, from empty -> next cycle instr=0x022081D7, instr_valid=1.
REQ-026 SHALL cover: LOAD op=6 (strided, 32-bit), vd=4, src1=10, src2=11 -> instr=0x0AB56207.
REQ-027 SHALL cover: vsetvli vtype=0x010, rd=5, rs1=6, followed by vadd, both with instr_ready=1 -> 0x010372D7 issued, vadd held with instr_valid=0 until a cfg_done pulse, then issued the next cycle.
REQ-028 SHALL cover: MUL with src_sel=VI -> err high for 1 cycle, FIFO count unchanged, req_ready stays 1.
REQ-029 SHALL cover: DEPTH+1 back-to-back requests with instr_ready=0 -> req_ready=0 after DEPTH accepts; after releasing instr_ready, outputs appear in order with no loss.
REQ-030 SHALL cover: nrst pulsed with 3 queued entries -> instr_valid=0 immediately, and the next push is issued alone.
